// File: rtl/sccb_arbiter.sv
// Arbitrates two SCCB write requesters (init table, runtime config) onto one sccb_sender,
// with a post-reset boot delay, round-robin grant, inter-write gap and a stuck-sender timeout.
module sccb_arbiter #(
  parameter int unsigned BOOT_DELAY = 1000,
  parameter int unsigned GAP_CYCLES = 16,
  parameter int unsigned TIMEOUT    = 65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        init_req,
  input  logic [15:0] init_data,
  input  logic        init_done,
  output logic        init_ack,
  input  logic        user_req,
  input  logic [15:0] user_data,
  output logic        user_ack,
  output logic [15:0] data_send,
  output logic        reg_ok,
  input  logic        sccb_ok,
  output logic        busy,
  output logic        timeout_err
);

  localparam int unsigned MAX_BG = (BOOT_DELAY > GAP_CYCLES) ? BOOT_DELAY : GAP_CYCLES;
  localparam int unsigned MAX_P  = (MAX_BG > TIMEOUT) ? MAX_BG : TIMEOUT;
  localparam int          CW     = (MAX_P < 1) ? 1 : $clog2(MAX_P + 1);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_IDLE = 2'd1,
    ST_WAIT = 2'd2,
    ST_GAP  = 2'd3
  } state_t;

  // Handshake: reg_ok is a level that stays high for the whole WAIT state; the sender
  // answers with a single-cycle sccb_ok; the granted requester then sees a one-cycle ack.
  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          last_user, last_user_n;   // 1 = user was granted most recently
  logic          owner_user, owner_user_n; // requester owning the outstanding write
  logic [15:0]   data_n;
  logic          reg_ok_n, init_ack_n, user_ack_n, timeout_err_n;

  logic [31:0]   cnt_inc;
  logic          init_elig, user_elig, grant_init, grant_user;

  assign busy = (state != ST_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_BOOT;
      cnt         <= '0;
      last_user   <= 1'b1;
      owner_user  <= 1'b0;
      data_send   <= 16'h0000;
      reg_ok      <= 1'b0;
      init_ack    <= 1'b0;
      user_ack    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      last_user   <= last_user_n;
      owner_user  <= owner_user_n;
      data_send   <= data_n;
      reg_ok      <= reg_ok_n;
      init_ack    <= init_ack_n;
      user_ack    <= user_ack_n;
      timeout_err <= timeout_err_n;
    end
  end

  // A requester whose ack is high this cycle has not yet had a chance to drop req,
  // so it is masked to avoid re-granting the write just completed (matters when GAP_CYCLES==0).
  always_comb begin
    cnt_inc    = 32'(cnt) + 32'd1;
    init_elig  = init_req && !init_ack;
    user_elig  = user_req && init_done && !user_ack;
    grant_init = init_elig && (!user_elig || last_user);
    grant_user = user_elig && (!init_elig || !last_user);
  end

  always_comb begin
    state_n       = state;
    cnt_n         = cnt;
    last_user_n   = last_user;
    owner_user_n  = owner_user;
    data_n        = data_send;
    reg_ok_n      = reg_ok;
    init_ack_n    = 1'b0;
    user_ack_n    = 1'b0;
    timeout_err_n = timeout_err;

    case (state)
      ST_BOOT: begin
        if (cnt_inc >= BOOT_DELAY) begin
          state_n = ST_IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end

      ST_IDLE: begin
        cnt_n = '0;
        if (grant_init || grant_user) begin
          state_n      = ST_WAIT;
          reg_ok_n     = 1'b1;
          owner_user_n = grant_user;
          last_user_n  = grant_user;
          data_n       = grant_user ? user_data : init_data;
        end
      end

      ST_WAIT: begin
        if (sccb_ok || (cnt_inc >= TIMEOUT)) begin
          reg_ok_n   = 1'b0;
          init_ack_n = !owner_user;
          user_ack_n = owner_user;
          if (!sccb_ok) timeout_err_n = 1'b1;
          cnt_n   = '0;
          state_n = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end

      ST_GAP: begin
        if (cnt_inc >= GAP_CYCLES) begin
          state_n = ST_IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end

      default: begin
        state_n = ST_BOOT;
        cnt_n   = '0;
      end
    endcase
  end

endmodule
